// File: rtl/bcd_sched_pkg.sv
// Shared constants, FSM state type and the leading-zero blanking helper
// for the BCD conversion scheduler.
package bcd_sched_pkg;

  localparam int unsigned BIN_W     = 20;
  localparam int unsigned DIGITS    = 6;
  localparam int unsigned BCD_W     = 24;
  localparam int unsigned CONV_BITS = 20;
  localparam int unsigned MAX_DEC   = 999999;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  // Replace leading zero digits (from the top down) with the blank code; digit 0 is always kept.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
    logic lead;
    blank_leading = bcd;
    lead = 1'b1;
    for (int unsigned d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (bcd[4*d +: 4] == 4'd0)) begin
        blank_leading[4*d +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction

endpackage

// File: rtl/bcd_shift_engine.sv
// Shift-add-3 (double dabble) engine: one add-3-then-shift step per enabled cycle.
module bcd_shift_engine (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [19:0] operand_i,
  output logic [23:0] digits_next_o
);
  import bcd_sched_pkg::*;

  logic [CONV_BITS-1:0] op_q;
  logic [BCD_W-1:0]     dig_q;
  logic [BCD_W-1:0]     adj;
  logic [CONV_BITS-1:0] op_next;

  always_comb begin
    adj = dig_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (dig_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = dig_q[4*d +: 4] + 4'd3;
      end
    end
    digits_next_o = {adj[BCD_W-2:0], op_q[CONV_BITS-1]};
    op_next       = {op_q[CONV_BITS-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q  <= '0;
      dig_q <= '0;
    end else if (load_i) begin
      op_q  <= operand_i;
      dig_q <= '0;
    end else if (step_i) begin
      op_q  <= op_next;
      dig_q <= digits_next_o;
    end
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD engine among NUM_REQ requesters.
// Optional leading-zero blanking of the result: define BCD_SCHED_BLANK_EN.
module bcd_convert_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned BIN_W   = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*BIN_W-1:0] bin_in_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               done_id_o,
  output logic [23:0]              bcd_out_o,
  output logic                     overflow_o
);
  import bcd_sched_pkg::*;

  state_e state_q, state_d;

  logic [1:0]           ptr_q;
  logic [4:0]           cnt_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 done_q;
  logic [1:0]           done_id_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 overflow_q;
  logic                 job_ovf_q;
  logic [1:0]           job_id_q;

  logic                 found;
  logic [1:0]           win;
  logic [BIN_W-1:0]     sel_op;
  logic                 sel_ovf;
  logic [CONV_BITS-1:0] clamped;
  logic                 load, step;
  logic [BCD_W-1:0]     digits_next;
  logic [BCD_W-1:0]     result;

  // Search starts just after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && |(req_i & (NUM_REQ'(1) << idx))) begin
        found = 1'b1;
        win   = 2'(idx);
      end
    end
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(win) == i) sel_op = bin_in_i[i*BIN_W +: BIN_W];
    end
    sel_ovf = sel_op > BIN_W'(MAX_DEC);
    clamped = sel_ovf ? CONV_BITS'(MAX_DEC) : sel_op[CONV_BITS-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = CONV;
      CONV:    if (cnt_q == 5'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    load   = (state_q == IDLE) && found;
    step   = (state_q == CONV);
  end

  bcd_shift_engine u_engine (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .load_i        (load),
    .step_i        (step),
    .operand_i     (clamped),
    .digits_next_o (digits_next)
  );

  always_comb begin
`ifdef BCD_SCHED_BLANK_EN
    result = blank_leading(digits_next);
`else
    result = digits_next;
`endif
  end

  // The result register takes the engine's final step directly so it is visible in the DONE cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q      <= 2'(NUM_REQ - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      job_ovf_q  <= 1'b0;
      job_id_q   <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      if (load) begin
        grant_q   <= NUM_REQ'(1) << win;
        ptr_q     <= win;
        cnt_q     <= 5'(CONV_BITS - 1);
        job_ovf_q <= sel_ovf;
        job_id_q  <= win;
      end
      if (step) begin
        if (cnt_q != 5'd0) begin
          cnt_q <= cnt_q - 5'd1;
        end else begin
          done_q     <= 1'b1;
          bcd_q      <= result;
          overflow_q <= job_ovf_q;
          done_id_q  <= job_id_q;
        end
      end
    end
  end

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign bcd_out_o  = bcd_q;
  assign overflow_o = overflow_q;

endmodule
